// File: rtl/mpeg2_seq_ctrl.sv
// rtl/mpeg2_seq_ctrl.sv - sequence controller gating a 4-pixel YUV stream into the MPEG2 encoder
module mpeg2_seq_ctrl #(
  parameter int XL = 6,
  parameter int YL = 6
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [6:0]  cfg_xsize16,
  input  logic [6:0]  cfg_ysize16,
  input  logic [15:0] cfg_nframes,
  input  logic        start,
  input  logic        abort,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [95:0] s_data,
  output logic [6:0]  enc_xsize16,
  output logic [6:0]  enc_ysize16,
  output logic        enc_en,
  output logic [95:0] enc_data,
  output logic        enc_sequence_stop,
  input  logic        enc_sequence_busy,
  input  logic        enc_o_en,
  input  logic        enc_o_last,
  output logic        busy,
  output logic        done,
  output logic        cfg_err,
  output logic [15:0] frame_idx,
  output logic [31:0] out_words
);

  localparam logic [6:0] XMAX = 7'(1 << XL);
  localparam logic [6:0] YMAX = 7'(1 << YL);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [6:0]  xs_q, xs_d, ys_q, ys_d;
  logic [15:0] nframes_q, nframes_d;
  logic [8:0]  col_q, col_d;
  logic [10:0] row_q, row_d;
  logic [15:0] frame_idx_q, frame_idx_d;
  logic        abort_q, abort_d;
  logic        last_seen_q, last_seen_d;
  logic        enc_en_q, enc_en_d;
  logic [95:0] enc_data_q, enc_data_d;
  logic        stop_q, stop_d;
  logic        done_q, done_d;
  logic        cfg_err_q, cfg_err_d;
  logic [31:0] out_words_q, out_words_d;

  logic        cfg_ok;
  logic [8:0]  col_max;
  logic [10:0] row_max;

  assign cfg_ok  = (cfg_xsize16 != 7'd0) && (cfg_xsize16 <= XMAX) &&
                   (cfg_ysize16 != 7'd0) && (cfg_ysize16 <= YMAX) &&
                   (cfg_nframes != 16'd0);
  assign col_max = {xs_q, 2'b00} - 9'd1;
  assign row_max = {ys_q, 4'b0000} - 11'd1;

  always_comb begin
    state_d     = state_q;
    xs_d        = xs_q;
    ys_d        = ys_q;
    nframes_d   = nframes_q;
    col_d       = col_q;
    row_d       = row_q;
    frame_idx_d = frame_idx_q;
    abort_d     = abort_q;
    last_seen_d = last_seen_q;
    enc_en_d    = 1'b0;
    enc_data_d  = enc_data_q;
    stop_d      = 1'b0;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    out_words_d = out_words_q;

    if (state_q != S_IDLE && enc_o_en && out_words_q != '1)
      out_words_d = out_words_q + 32'd1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!cfg_ok) begin
            cfg_err_d = 1'b1;
          end else if (!enc_sequence_busy) begin
            state_d     = S_RUN;
            xs_d        = cfg_xsize16;
            ys_d        = cfg_ysize16;
            nframes_d   = cfg_nframes;
            col_d       = 9'd0;
            row_d       = 11'd0;
            frame_idx_d = 16'd0;
            out_words_d = 32'd0;
            abort_d     = 1'b0;
            last_seen_d = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (abort) abort_d = 1'b1;
        if (s_valid) begin
          enc_en_d   = 1'b1;
          enc_data_d = s_data;
          if (col_q == col_max) begin
            col_d = 9'd0;
            if (row_q == row_max) begin
              row_d       = 11'd0;
              frame_idx_d = frame_idx_q + 16'd1;
              // A pending abort only takes effect here, so frames are never cut short.
              if ((frame_idx_q + 16'd1 == nframes_q) || abort_q || abort)
                state_d = S_STOP;
            end else begin
              row_d = row_q + 11'd1;
            end
          end else begin
            col_d = col_q + 9'd1;
          end
        end
      end
      S_STOP: begin
        stop_d  = 1'b1;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (enc_o_en && enc_o_last) last_seen_d = 1'b1;
        if (last_seen_q && !enc_sequence_busy) begin
          state_d     = S_IDLE;
          done_d      = 1'b1;
          abort_d     = 1'b0;
          last_seen_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      xs_q        <= 7'd0;
      ys_q        <= 7'd0;
      nframes_q   <= 16'd0;
      col_q       <= 9'd0;
      row_q       <= 11'd0;
      frame_idx_q <= 16'd0;
      abort_q     <= 1'b0;
      last_seen_q <= 1'b0;
      enc_en_q    <= 1'b0;
      enc_data_q  <= 96'd0;
      stop_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      out_words_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      xs_q        <= xs_d;
      ys_q        <= ys_d;
      nframes_q   <= nframes_d;
      col_q       <= col_d;
      row_q       <= row_d;
      frame_idx_q <= frame_idx_d;
      abort_q     <= abort_d;
      last_seen_q <= last_seen_d;
      enc_en_q    <= enc_en_d;
      enc_data_q  <= enc_data_d;
      stop_q      <= stop_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      out_words_q <= out_words_d;
    end
  end

  assign s_ready           = (state_q == S_RUN);
  assign busy              = (state_q != S_IDLE);
  assign enc_xsize16       = xs_q;
  assign enc_ysize16       = ys_q;
  assign enc_en            = enc_en_q;
  assign enc_data          = enc_data_q;
  assign enc_sequence_stop = stop_q;
  assign done              = done_q;
  assign cfg_err           = cfg_err_q;
  assign frame_idx         = frame_idx_q;
  assign out_words         = out_words_q;

endmodule

// File: doc/mpeg2_seq_ctrl.md
# mpeg2_seq_ctrl

Sequence controller in front of the MPEG2 encoder core. It latches a frame geometry and a frame count, and gates an upstream 4-pixel-per-beat YUV 4:4:4 stream into the encoder's `i_en`/pixel port with exact per-frame beat accounting. After the last frame, or after an abort at a frame boundary, it issues the one-cycle `sequence_stop`, drains the encoder until its last output word, and reports completion.

## Interface
- `XL`, 6: horizontal size limit; `cfg_xsize16` max = 2^XL.
- `YL`, 6: vertical size limit; `cfg_ysize16` max = 2^YL.
- `clk`  in  1  clock, all logic on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `cfg_xsize16`  in  7  frame width / 16; sampled on accepted `start`.
- `cfg_ysize16`  in  7  frame height / 16; sampled on accepted `start`.
- `cfg_nframes`  in  16  frames in the sequence; sampled on accepted `start`.
- `start`  in  1  one-cycle request to begin a sequence.
- `abort`  in  1  request to end the sequence after the current frame.
- `s_valid`  in  1  upstream beat valid.
- `s_ready`  out  1  upstream beat accept.
- `s_data`  in  96  {Y3,Y2,Y1,Y0,U3..U0,V3..V0}, byte 0 = LSB of each group.
- `enc_xsize16`, `enc_ysize16`  out  7 each  latched geometry to the encoder.
- `enc_en`  out  1  encoder pixel strobe.
- `enc_data`  out  96  encoder pixels, same packing as `s_data`.
- `enc_sequence_stop`  out  1  one-cycle stop pulse to the encoder.
- `enc_sequence_busy`  in  1  encoder busy.
- `enc_o_en`, `enc_o_last`  in  1 each  encoder output-stream strobe and last marker.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `cfg_err`  out  1  one-cycle pulse when `start` is rejected for bad configuration.
- `frame_idx`  out  16  number of frames fully fed.
- `out_words`  out  32  number of `enc_o_en` beats seen since the last accepted start.

## Operation
- States: IDLE, RUN, STOP, DRAIN.
- IDLE -> RUN on `start` when all of the following hold:
  - `1 <= cfg_xsize16 <= 2^XL`
  - `1 <= cfg_ysize16 <= 2^YL`
  - `cfg_nframes != 0`
  - `enc_sequence_busy == 0`
- On IDLE -> RUN: latch the configuration, clear all counters, clear `out_words`.
- `start` with a geometry or `cfg_nframes` violation: pulse `cfg_err`, stay IDLE.
- `start` while the encoder is busy (with an otherwise valid configuration): ignored silently, stay IDLE.
- `start` in any state other than IDLE: ignored.
- RUN: `s_ready = 1` (combinational from the state). Each accepted beat (`s_valid & s_ready`) advances the counters.
- Counters:
  - `col` (9 bits) wraps at `xsize16*4 - 1`.
  - `row` (11 bits) advances on `col` wrap and wraps at `ysize16*16 - 1`.
  - A `row` wrap is a frame end: `frame_idx` increments.
- At frame end, go RUN -> STOP when `frame_idx + 1 == nframes` or the abort flag is set; otherwise stay in RUN.
- `abort` is sticky: it is latched in RUN and cleared on entering IDLE. It never truncates a frame. `abort` in IDLE, STOP or DRAIN has no effect.
- STOP: one cycle only, then DRAIN.
- DRAIN: set a sticky `last_seen` when `enc_o_en & enc_o_last`. Go to IDLE when `last_seen & !enc_sequence_busy`, pulsing `done` in that cycle.
- `out_words` increments on every `enc_o_en` while `busy`. It saturates at 2^32-1.

## Timing
- Reset values: all outputs 0, including `enc_*` and the counters; state = IDLE.
- A reset mid-sequence returns to IDLE immediately with no stop pulse.
- `enc_en`/`enc_data` are registered: a beat accepted at cycle T appears at T+1. `enc_data` holds its value when `enc_en` is low.
- Final beat accepted at T:
  - `s_ready` low from T+1.
  - `enc_en` high at T+1.
  - `enc_sequence_stop` high at T+2 only.
- `enc_o_last` arriving in the same cycle DRAIN is entered is captured.
- `done` is registered and asserts one cycle after the exit condition is met; `busy` falls in that same cycle.
- `enc_xsize16`/`enc_ysize16` are stable from T+1 after start through the `done` cycle and hold until the next accepted start.
- Throughput: one beat per cycle when `s_valid` is held high; no bubbles at row or frame boundaries.

## Test plan
- Reset, then xsize16=1, ysize16=1, nframes=2, `s_valid` constantly 1:
  - exactly 128 `enc_en` beats;
  - `frame_idx` = 1 after beat 64 and 2 after beat 128;
  - stop pulse 2 cycles after the final accept.
  - Then drive `enc_o_last` with `enc_sequence_busy` falling 5 cycles later -> `done` one cycle after busy low.
- Random `s_valid` (50% duty), xsize16=2, ysize16=1, nframes=1:
  - 128 beats delivered in order;
  - `enc_data` equals the accepted `s_data` sequence with no drops or duplicates.
- `abort` at beat 10 of frame 0 with nframes=5 -> feeding continues to beat 64; stop after frame 0; final `frame_idx` = 1.
- Config errors -> `cfg_err` pulse, state stays IDLE:
  - `start` with xsize16=0;
  - `start` with ysize16=65 (YL=6);
  - `start` with nframes=0.
- `start` while `enc_sequence_busy` = 1 -> ignored, `busy` stays 0. A second `start` during RUN -> no effect on the counters.
- `rstn` pulsed low mid-frame:
  - all outputs 0 asynchronously and no stop pulse;
  - a new start then runs normally from `col` = `row` = 0.
